// File: rtl/decode_stage_pkg.sv
// Shared encodings and field layout for the pipelined instruction decoder.
// Holds opcode/ALU-op constants, field bit positions and the class lookup.
package decode_stage_pkg;

    localparam int unsigned FIELD_W  = 5;
    localparam int unsigned OPC_LO   = 27;
    localparam int unsigned RD_LO    = 22;
    localparam int unsigned RS_LO    = 17;
    localparam int unsigned RT_LO    = 12;
    localparam int unsigned SHAMT_LO = 7;
    localparam int unsigned ALU_LO   = 2;

    typedef enum logic [FIELD_W-1:0] {
        OP_RTYPE = 5'b00000,
        OP_ADDI  = 5'b00101,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000
    } opcode_e;

    typedef enum logic [FIELD_W-1:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_SLL = 5'b00100,
        ALU_SRA = 5'b00101
    } alu_op_e;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_and;
        logic is_or;
        logic is_sll;
        logic is_sra;
        logic is_addi;
        logic is_lw;
        logic is_sw;
        logic illegal;
    } class_t;

    // Exactly one member of the returned struct is set for any input.
    function automatic class_t classify(input logic [FIELD_W-1:0] opcode,
                                        input logic [FIELD_W-1:0] alu_op);
        class_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                case (alu_op)
                    ALU_ADD: c.is_add  = 1'b1;
                    ALU_SUB: c.is_sub  = 1'b1;
                    ALU_AND: c.is_and  = 1'b1;
                    ALU_OR:  c.is_or   = 1'b1;
                    ALU_SLL: c.is_sll  = 1'b1;
                    ALU_SRA: c.is_sra  = 1'b1;
                    default: c.illegal = 1'b1;
                endcase
            end
            OP_ADDI: c.is_addi = 1'b1;
            OP_SW:   c.is_sw   = 1'b1;
            OP_LW:   c.is_lw   = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute stream signals for decode_stage.
// The slave modport is the decoder's view; master is the surrounding pipeline.
interface decode_stage_if #(
    parameter int unsigned INSN_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [INSN_W-1:0] in_insn;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_opcode;
    logic [REG_AW-1:0] out_rd;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [4:0]        out_shamt;
    logic [4:0]        out_alu_op;
    logic [DATA_W-1:0] out_imm;
    logic              out_is_add;
    logic              out_is_sub;
    logic              out_is_and;
    logic              out_is_or;
    logic              out_is_sll;
    logic              out_is_sra;
    logic              out_is_addi;
    logic              out_is_lw;
    logic              out_is_sw;
    logic              out_illegal;
    logic              out_writes_rd;

    modport slave (
        input  in_valid, in_insn, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_is_add, out_is_sub,
               out_is_and, out_is_or, out_is_sll, out_is_sra, out_is_addi,
               out_is_lw, out_is_sw, out_illegal, out_writes_rd
    );

    modport master (
        output in_valid, in_insn, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_is_add, out_is_sub,
               out_is_and, out_is_or, out_is_sll, out_is_sra, out_is_addi,
               out_is_lw, out_is_sw, out_illegal, out_writes_rd
    );
endinterface

// File: rtl/decode_stage_reg_scoreboard.sv
// Per-register pending-write scoreboard with a two-source RAW hazard lookup.
// A same-cycle writeback is masked before lookup (write-before-read regfile).
module reg_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_rd,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_rd,
    input  logic                src_a_en,
    input  logic [REG_AW-1:0]   src_a,
    input  logic                src_b_en,
    input  logic [REG_AW-1:0]   src_b,
    output logic                hazard,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] visible;
    logic [NUM_REGS-1:0] next_pending;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
        visible      = pending & ~clr_mask;
        // Set is applied after clear so a same-cycle set on the same register wins.
        next_pending = visible | set_mask;
        next_pending[0] = 1'b0;
    end

    always_comb begin
        hazard = 1'b0;
        if (src_a_en && (src_a != '0) && visible[src_a]) hazard = 1'b1;
        if (src_b_en && (src_b != '0) && visible[src_b]) hazard = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) pending <= '0;
        else                pending <= next_pending;
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined instruction decoder: splits fields, sign-extends the immediate,
// raises class flags and stalls on RAW hazards; registered 1-cycle output.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned INSN_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned IMM_W    = 17
) (
    input  logic                clock,
    input  logic                reset,
    decode_stage_if.slave       bus,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending
);

    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] alu_field;
    logic [FIELD_W-1:0] shamt;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [DATA_W-1:0]  imm_ext;
    class_t             cls;
    logic               writes_rd;
    logic               src_a_en;
    logic               src_b_en;
    logic [REG_AW-1:0]  src_b;
    logic               hazard;
    logic               valid_q;
    logic               accept;

    assign opcode    = bus.in_insn[OPC_LO +: FIELD_W];
    assign rd        = bus.in_insn[RD_LO +: REG_AW];
    assign rs        = bus.in_insn[RS_LO +: REG_AW];
    assign rt        = bus.in_insn[RT_LO +: REG_AW];
    assign shamt     = bus.in_insn[SHAMT_LO +: FIELD_W];
    assign alu_field = bus.in_insn[ALU_LO +: FIELD_W];
    assign imm_ext   = DATA_W'($signed(bus.in_insn[IMM_W-1:0]));
    assign cls       = classify(opcode, alu_field);

    assign writes_rd = (cls.is_add | cls.is_sub | cls.is_and | cls.is_or |
                        cls.is_sll | cls.is_sra | cls.is_addi | cls.is_lw) &&
                       (rd != '0);

    // Every legal class reads rs; the second source is rt for ALU ops or rd for stores.
    assign src_a_en = bus.in_valid && !cls.illegal;
    assign src_b_en = bus.in_valid &&
                      (cls.is_add | cls.is_sub | cls.is_and | cls.is_or | cls.is_sw);
    assign src_b    = cls.is_sw ? rd : rt;

    assign bus.in_ready  = !reset && (!valid_q || bus.out_ready) && !hazard && !flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_q;

    reg_scoreboard #(
        .REG_AW   (REG_AW),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .set_en   (accept && writes_rd),
        .set_rd   (rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .src_a_en (src_a_en),
        .src_a    (rs),
        .src_b_en (src_b_en),
        .src_b    (src_b),
        .hazard   (hazard),
        .pending  (pending)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q           <= 1'b0;
            bus.out_opcode    <= '0;
            bus.out_rd        <= '0;
            bus.out_rs        <= '0;
            bus.out_rt        <= '0;
            bus.out_shamt     <= '0;
            bus.out_alu_op    <= '0;
            bus.out_imm       <= '0;
            bus.out_is_add    <= 1'b0;
            bus.out_is_sub    <= 1'b0;
            bus.out_is_and    <= 1'b0;
            bus.out_is_or     <= 1'b0;
            bus.out_is_sll    <= 1'b0;
            bus.out_is_sra    <= 1'b0;
            bus.out_is_addi   <= 1'b0;
            bus.out_is_lw     <= 1'b0;
            bus.out_is_sw     <= 1'b0;
            bus.out_illegal   <= 1'b0;
            bus.out_writes_rd <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q           <= 1'b1;
            bus.out_opcode    <= opcode;
            bus.out_rd        <= rd;
            bus.out_rs        <= rs;
            bus.out_rt        <= rt;
            bus.out_shamt     <= shamt;
            bus.out_alu_op    <= (opcode == OP_RTYPE) ? alu_field : '0;
            bus.out_imm       <= imm_ext;
            bus.out_is_add    <= cls.is_add;
            bus.out_is_sub    <= cls.is_sub;
            bus.out_is_and    <= cls.is_and;
            bus.out_is_or     <= cls.is_or;
            bus.out_is_sll    <= cls.is_sll;
            bus.out_is_sra    <= cls.is_sra;
            bus.out_is_addi   <= cls.is_addi;
            bus.out_is_lw     <= cls.is_lw;
            bus.out_is_sw     <= cls.is_sw;
            bus.out_illegal   <= cls.illegal;
            bus.out_writes_rd <= writes_rd;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expected bundles,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_decode_stage;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [8:0]  flags;   // {add,sub,and,or,sll,sra,addi,lw,sw}
        logic        illegal;
        logic        writes;
    } exp_t;

    localparam logic [8:0] F_ADD  = 9'h100;
    localparam logic [8:0] F_SUB  = 9'h080;
    localparam logic [8:0] F_AND  = 9'h040;
    localparam logic [8:0] F_OR   = 9'h020;
    localparam logic [8:0] F_SLL  = 9'h010;
    localparam logic [8:0] F_SRA  = 9'h008;
    localparam logic [8:0] F_ADDI = 9'h004;
    localparam logic [8:0] F_LW   = 9'h002;
    localparam logic [8:0] F_SW   = 9'h001;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] pending;

    int checks   = 0;
    int failures = 0;
    exp_t q[$];

    decode_stage_if #(.INSN_W(32), .DATA_W(32), .REG_AW(5)) bus ();

    decode_stage #(
        .INSN_W   (32),
        .DATA_W   (32),
        .REG_AW   (5),
        .NUM_REGS (32),
        .IMM_W    (17)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .flush    (flush),
        .pending  (pending)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [4:0] opc, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] sh, input logic [4:0] alu,
                                input logic [31:0] imm, input logic [8:0] fl,
                                input logic ill, input logic wr);
        exp_t e;
        e.opcode = opc; e.rd = rd; e.rs = rs; e.rt = rt; e.shamt = sh;
        e.alu = alu; e.imm = imm; e.flags = fl; e.illegal = ill; e.writes = wr;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.opcode = bus.out_opcode; a.rd = bus.out_rd; a.rs = bus.out_rs;
        a.rt = bus.out_rt; a.shamt = bus.out_shamt; a.alu = bus.out_alu_op;
        a.imm = bus.out_imm;
        a.flags = {bus.out_is_add, bus.out_is_sub, bus.out_is_and, bus.out_is_or,
                   bus.out_is_sll, bus.out_is_sra, bus.out_is_addi, bus.out_is_lw,
                   bus.out_is_sw};
        a.illegal = bus.out_illegal; a.writes = bus.out_writes_rd;
        return a;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every consumed bundle must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bundle: got %0h expected none", actual());
            end else begin
                chk("bundle", 128'(actual()), 128'(q.pop_front()));
            end
        end
    end

    // Entered at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] insn, input exp_t e, output int waited);
        logic accepted;
        accepted = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_insn = insn;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                q.push_back(e);
                accepted = 1'b1;
                break;
            end
            waited++;
            @(posedge clock); #1;
        end
        chk("send_accept", 128'(accepted), 128'(1'b1));
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        bus.in_valid = 1'b0; bus.in_insn = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1'b0));
        chk("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("reset_pending", 128'(pending), 128'(32'h0));
        chk("reset_outputs", 128'(actual()), 128'(exp_t'('0)));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
        @(posedge clock); #1;

        // add $3,$1,$2
        send(32'h00C22000, mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00002000, F_ADD, 1'b0, 1'b1), w);
        @(negedge clock);
        chk("pending_after_add", 128'(pending), 128'(32'h8));
        @(posedge clock); #1;

        // addi $4,$3,-1 stalls on $3 until writeback of $3
        bus.in_valid = 1'b1; bus.in_insn = 32'h2907FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("raw_stall_in_ready", 128'(bus.in_ready), 128'(1'b0));
            @(posedge clock); #1;
        end
        wb_valid = 1'b1; wb_rd = 5'd3;
        @(negedge clock);
        chk("raw_release_in_ready", 128'(bus.in_ready), 128'(1'b1));
        q.push_back(mk(5'd5, 5'd4, 5'd3, 5'd31, 5'd31, 5'd0, 32'hFFFFFFFF, F_ADDI, 1'b0, 1'b1));
        @(posedge clock); #1;
        bus.in_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clock);
        chk("pending_after_addi", 128'(pending), 128'(32'h10));
        @(posedge clock); #1;
        wb_valid = 1'b1; wb_rd = 5'd4;
        @(posedge clock); #1;
        wb_valid = 1'b0;
        @(negedge clock);
        chk("pending_cleared", 128'(pending), 128'(32'h0));
        @(posedge clock); #1;

        // Backpressure: and $6,$7,$8 held, then or $9,$10,$11 follows
        bus.out_ready = 1'b0;
        send(32'h018E8008, mk(5'd0, 5'd6, 5'd7, 5'd8, 5'd0, 5'd2, 32'h00008008, F_AND, 1'b0, 1'b1), w);
        bus.in_valid = 1'b1; bus.in_insn = 32'h0254B00C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_in_ready", 128'(bus.in_ready), 128'(1'b0));
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1'b1));
            chk("bp_hold", 128'(actual()), 128'(q[0]));
            @(posedge clock); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'(1'b1));
        q.push_back(mk(5'd0, 5'd9, 5'd10, 5'd11, 5'd0, 5'd3, 32'h0000B00C, F_OR, 1'b0, 1'b1));
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("pending_after_bp", 128'(pending), 128'(32'h240));
        @(posedge clock); #1;

        // Illegal opcode 11111 reading pending $6, then R-type alu_op 00110 reading $9
        send(32'hF98C0000, mk(5'd31, 5'd6, 5'd6, 5'd0, 5'd0, 5'd0, 32'h0, 9'h0, 1'b1, 1'b0), w);
        chk("illegal_op_no_stall", 128'(w), 128'(0));
        send(32'h00526018, mk(5'd0, 5'd1, 5'd9, 5'd6, 5'd0, 5'd6, 32'h00006018, 9'h0, 1'b1, 1'b0), w);
        chk("illegal_alu_no_stall", 128'(w), 128'(0));
        @(negedge clock);
        chk("pending_after_illegal", 128'(pending), 128'(32'h240));
        @(posedge clock); #1;

        // addi $0,$1,5 writes nothing
        send(32'h28020005, mk(5'd5, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 32'h5, F_ADDI, 1'b0, 1'b0), w);
        @(negedge clock);
        chk("pending_rd0", 128'(pending), 128'(32'h240));
        @(posedge clock); #1;

        // sll $5,$1,3 then lw $5,-4($1) accepted alongside writeback of $5
        send(32'h01420190, mk(5'd0, 5'd5, 5'd1, 5'd0, 5'd3, 5'd4, 32'h190, F_SLL, 1'b0, 1'b1), w);
        wb_valid = 1'b1; wb_rd = 5'd5;
        send(32'h4143FFFC, mk(5'd8, 5'd5, 5'd1, 5'd31, 5'd31, 5'd0, 32'hFFFFFFFC, F_LW, 1'b0, 1'b1), w);
        wb_valid = 1'b0;
        @(negedge clock);
        chk("pending_set_wins", 128'(pending), 128'(32'h260));
        @(posedge clock); #1;

        // sw $2,8($1); sub $7,$1,$2
        send(32'h38820008, mk(5'd7, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 32'h8, F_SW, 1'b0, 1'b0), w);
        send(32'h01C22004, mk(5'd0, 5'd7, 5'd1, 5'd2, 5'd0, 5'd1, 32'h2004, F_SUB, 1'b0, 1'b1), w);
        @(negedge clock);
        chk("pending_after_sub", 128'(pending), 128'(32'h2E0));
        @(posedge clock); #1;
        wb_valid = 1'b1; wb_rd = 5'd3;
        @(posedge clock); #1;
        wb_valid = 1'b0;
        @(negedge clock);
        chk("wb_not_pending", 128'(pending), 128'(32'h2E0));
        @(posedge clock); #1;

        // sra $8,$1,1 then flush while its bundle is still held
        send(32'h02020094, mk(5'd0, 5'd8, 5'd1, 5'd0, 5'd1, 5'd5, 32'h94, F_SRA, 1'b0, 1'b1), w);
        bus.out_ready = 1'b0;
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_insn = 32'h00C22000;
        @(negedge clock);
        chk("flush_in_ready", 128'(bus.in_ready), 128'(1'b0));
        chk("pre_flush_valid", 128'(bus.out_valid), 128'(1'b1));
        chk("pre_flush_pending", 128'(pending), 128'(32'h3E0));
        void'(q.pop_front());
        @(posedge clock); #1;
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clock);
        chk("flush_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("flush_pending", 128'(pending), 128'(32'h0));

        repeat (3) @(negedge clock);
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined successor to the combinational instruction decoder.
- Accepts fetched instructions over a valid/ready handshake and splits them into fields.
- Sign-extends the immediate to datapath width and raises one-hot class flags.
- Stalls on read-after-write hazards using a per-register pending-write scoreboard.
- Sits between fetch and execute. Output is registered, with 1-cycle latency.

Parameters:
- INSN_W, 32, instruction width.
- DATA_W, 32, sign-extended immediate width. Must be at least IMM_W.
- REG_AW, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**REG_AW).
- IMM_W, 17, immediate field width (instruction[IMM_W-1:0]).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- in_insn  in  INSN_W  raw instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_opcode  out  5  instruction[31:27].
- out_rd / out_rs / out_rt  out  REG_AW each  [26:22] / [21:17] / [16:12].
- out_shamt  out  5  [11:7].
- out_alu_op  out  5  [6:2] for R-type; 0 otherwise.
- out_imm  out  DATA_W  sign-extended imm.
- out_is_add, out_is_sub, out_is_and, out_is_or, out_is_sll, out_is_sra, out_is_addi, out_is_lw, out_is_sw  out  1 each  class flags.
- out_illegal  out  1  unsupported opcode or alu_op.
- out_writes_rd  out  1  instruction writes rd, and rd != 0.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  REG_AW  register being written back.
- flush  in  1  squash the back-end.
- pending  out  NUM_REGS  scoreboard vector (debug/verification).

Behaviour:
- Opcode/alu_op codes:
  - R-type = 00000, with alu_op add=00000, sub=00001, and=00010, or=00011, sll=00100, sra=00101.
  - addi = 00101, sw = 00111, lw = 01000.
  - Any other opcode, or R-type alu_op > 00101, sets illegal.
- Source use:
  - R-type ALU ops use rs and rt.
  - sll and sra use rs only.
  - addi and lw use rs.
  - sw uses rs and rd (rd holds the store data).
  - Illegal instructions use no sources.
- Writers: R-type, addi and lw, when rd != 0.
- Hazard: in_valid is high and a used source register s != 0 has pending[s] set, where pending[s] is evaluated after masking out a same-cycle clear (wb_valid && wb_rd == s). The register file is write-before-read, so this forwarding is safe.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept = in_valid && in_ready. On accept, all decoded outputs load on the next edge, out_valid goes to 1, and pending[rd] is set if writes_rd.
- If out_valid && out_ready with no accept, out_valid goes to 0. Output fields hold their last value.
- When out_valid=1 and out_ready=0, all outputs hold stable.
- Scoreboard:
  - wb_valid clears pending[wb_rd].
  - If an accept sets the same register in the same cycle, the set wins.
  - pending[0] is always 0.
  - A writeback to a register that is not pending has no effect.
- flush (highest priority after reset): on the next edge out_valid goes to 0 and all pending bits clear. No accept occurs in a flush cycle.
- reset: out_valid=0, pending=0, and all data outputs and flags = 0. in_ready is 0 during reset and 1 in the first cycle after reset.
- Illegal instructions pass through with out_illegal=1, all class flags 0 and out_writes_rd=0. They never stall and never set pending.
- Exactly one class flag or out_illegal is 1 whenever out_valid=1.
- out_imm = {(DATA_W-IMM_W) copies of in_insn[IMM_W-1], in_insn[IMM_W-1:0]}.

Decomposition:
- Shared package holds:
  - the opcode constants (OP_RTYPE, OP_ADDI, OP_SW, OP_LW);
  - the ALU-op constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA);
  - the field bit positions.
- One sub-module, reg_scoreboard: the NUM_REGS pending vector with set/clear/flush ports and the two-source hazard lookup.

Test Plan:
- Basic decode: reset, then in_insn=0x00C22000 (add $3,$1,$2) with out_ready=1. One cycle later: out_valid=1, out_is_add=1, rd=3, rs=1, rt=2, out_writes_rd=1, pending=0x8.
- RAW stall: next in_insn=0x2907FFFF (addi $4,$3,-1). in_ready stays 0 until wb_valid=1 with wb_rd=3; in that same cycle it is accepted. Then out_imm=0xFFFFFFFF, out_is_addi=1, pending=0x10.
- Backpressure: out_ready=0 with two back-to-back independent instructions. First bundle is held stable, in_ready=0. Raising out_ready drains both in order, one per cycle.
- Illegal: in_insn opcode 11111, then R-type with alu_op 00110. Both give out_illegal=1, no stall, pending unchanged.
- Edge cases: rd=0 writer gives out_writes_rd=0 and pending unchanged. Same-cycle wb_rd=5 with accept of a writer to $5 leaves pending[5]=1.
- flush with out_valid=1 and pending=0x18: next cycle out_valid=0, pending=0. in_ready is 0 during the flush cycle.
